// File: rtl/result_mux_stage.sv
// Write-back result selector: ALU / formatted load data / PC+4 / immediate.
// Latency: Result is combinational (0 cycles); Result_Q/Valid_Q follow 1 cycle later.
// Backpressure: none; the stage always accepts, Valid_In only gates the register capture.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   ALUResult         ALU output; [1:0] doubles as the load byte offset
//   ReadData          raw aligned word from data memory
//   PC_Plus_4         link value for JAL/JALR
//   ImmExt            extended immediate for LUI
//   ResultSrc         00 ALU, 01 load, 10 PC+4, 11 immediate
//   Funct3            load type, only meaningful when ResultSrc = 01
//   Valid_In          instruction writes back this cycle
//   Result            combinational selected result
//   Result_Q, Valid_Q registered copy of Result (captured when valid) and of Valid_In
module result_mux_stage #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData,
    input  logic [31:0] PC_Plus_4,
    input  logic [31:0] ImmExt,
    input  logic [1:0]  ResultSrc,
    input  logic [2:0]  Funct3,
    input  logic        Valid_In,
    output logic [31:0] Result,
    output logic [31:0] Result_Q,
    output logic        Valid_Q
);

    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        valid_q;

    assign off = ALUResult[1:0];

    // Byte and halfword lane extraction. The halfword lane uses only off[1];
    // a misaligned halfword silently reads the lower-aligned half.
    always_comb begin
        byte_sel = ReadData[7:0];
        case (off)
            2'b00: byte_sel = ReadData[7:0];
            2'b01: byte_sel = ReadData[15:8];
            2'b10: byte_sel = ReadData[23:16];
            2'b11: byte_sel = ReadData[31:24];
            default: byte_sel = ReadData[7:0];
        endcase
        half_sel = off[1] ? ReadData[31:16] : ReadData[15:0];
    end

    // Load formatting; reserved encodings pass the raw word through.
    always_comb begin
        load_data = ReadData;
        case (Funct3)
            3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001: load_data = {{16{half_sel[15]}}, half_sel};
            3'b010: load_data = ReadData;
            3'b100: load_data = {24'h0, byte_sel};
            3'b101: load_data = {16'h0, half_sel};
            default: load_data = ReadData;
        endcase
    end

    // Explicit case keeps the output dependent only on the selected source.
    always_comb begin
        result_d = ALUResult;
        case (ResultSrc)
            2'b00: result_d = ALUResult;
            2'b01: result_d = load_data;
            2'b10: result_d = PC_Plus_4;
            2'b11: result_d = ImmExt;
            default: result_d = ALUResult;
        endcase
    end

    assign Result = result_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= RESET_VALUE;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= Valid_In;
            if (Valid_In) begin
                result_q <= result_d;
            end
        end
    end

    assign Result_Q = result_q;
    assign Valid_Q  = valid_q;

endmodule

// File: tb/tb_result_mux_stage.sv
module tb_result_mux_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] PC_Plus_4;
    logic [31:0] ImmExt;
    logic [1:0]  ResultSrc;
    logic [2:0]  Funct3;
    logic        Valid_In;
    logic [31:0] Result;
    logic [31:0] Result_Q;
    logic        Valid_Q;

    int vectors;
    int miscompares;

    result_mux_stage #(.RESET_VALUE(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUResult (ALUResult),
        .ReadData  (ReadData),
        .PC_Plus_4 (PC_Plus_4),
        .ImmExt    (ImmExt),
        .ResultSrc (ResultSrc),
        .Funct3    (Funct3),
        .Valid_In  (Valid_In),
        .Result    (Result),
        .Result_Q  (Result_Q),
        .Valid_Q   (Valid_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        ALUResult = 32'd1;
        ReadData  = 32'd2;
        PC_Plus_4 = 32'd3;
        ImmExt    = 32'd4;
        ResultSrc = 2'b00;
        Funct3    = 3'b010;
        Valid_In  = 1'b0;

        // Reset state
        #2;
        check("reset_result_q", Result_Q, 32'h0000_0000);
        check("reset_valid_q", {31'h0, Valid_Q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic select, 10 ns per stage
        ResultSrc = 2'b00; #10; check("sel_alu", Result, 32'd1);
        ResultSrc = 2'b01; #10; check("sel_load", Result, 32'd2);
        ResultSrc = 2'b10; #10; check("sel_pc4", Result, 32'd3);
        ResultSrc = 2'b11; #10; check("sel_imm", Result, 32'd4);

        // Byte loads
        ReadData  = 32'h80FF_7F01;
        ResultSrc = 2'b01;
        Funct3    = 3'b000;
        ALUResult = 32'h0000_1000; #1; check("lb_off0", Result, 32'h0000_0001);
        ALUResult = 32'h0000_1001; #1; check("lb_off1", Result, 32'h0000_007F);
        ALUResult = 32'h0000_1002; #1; check("lb_off2", Result, 32'hFFFF_FFFF);
        ALUResult = 32'h0000_1003; #1; check("lb_off3", Result, 32'hFFFF_FF80);
        Funct3    = 3'b100;
        ALUResult = 32'h0000_1002; #1; check("lbu_off2", Result, 32'h0000_00FF);
        ALUResult = 32'h0000_1003; #1; check("lbu_off3", Result, 32'h0000_0080);

        // Halfword loads
        ReadData  = 32'h8001_7FFE;
        Funct3    = 3'b001;
        ALUResult = 32'h0000_2000; #1; check("lh_off0", Result, 32'h0000_7FFE);
        ALUResult = 32'h0000_2002; #1; check("lh_off2", Result, 32'hFFFF_8001);
        ALUResult = 32'h0000_2001; #1; check("lh_off1", Result, 32'h0000_7FFE);
        Funct3    = 3'b101;
        ALUResult = 32'h0000_2002; #1; check("lhu_off2", Result, 32'h0000_8001);
        ALUResult = 32'h0000_2000; #1; check("lhu_off0", Result, 32'h0000_7FFE);

        // Word and reserved encodings pass the raw word
        Funct3    = 3'b010;
        ALUResult = 32'h0000_2003; #1; check("lw_off3", Result, 32'h8001_7FFE);
        Funct3    = 3'b011; #1; check("f3_011", Result, 32'h8001_7FFE);
        Funct3    = 3'b111; #1; check("f3_111", Result, 32'h8001_7FFE);

        // Funct3 independence outside load select
        ResultSrc = 2'b00;
        ALUResult = 32'h1234_5673;
        for (int f = 0; f < 8; f++) begin
            Funct3 = 3'(f);
            #1;
            check($sformatf("f3_indep_%0d", f), Result, 32'h1234_5673);
        end

        // Registered capture
        @(negedge clk);
        ResultSrc = 2'b00;
        ALUResult = 32'hDEAD_BEEF;
        Valid_In  = 1'b1;
        @(posedge clk); #1;
        check("cap_result_q", Result_Q, 32'hDEAD_BEEF);
        check("cap_valid_q", {31'h0, Valid_Q}, 32'h1);

        // Hold when not valid
        @(negedge clk);
        ALUResult = 32'h1111_2222;
        Valid_In  = 1'b0;
        @(posedge clk); #1;
        check("hold_result_q", Result_Q, 32'hDEAD_BEEF);
        check("hold_valid_q", {31'h0, Valid_Q}, 32'h0);

        // Source and data change together: capture reflects inputs at the edge
        @(negedge clk);
        ResultSrc = 2'b10;
        PC_Plus_4 = 32'h0000_4004;
        Valid_In  = 1'b1;
        @(posedge clk); #1;
        check("switch_result_q", Result_Q, 32'h0000_4004);

        // Async reset between edges
        @(negedge clk);
        ResultSrc = 2'b11;
        ImmExt    = 32'hABCD_E000;
        Valid_In  = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("arst_result_q", Result_Q, 32'h0000_0000);
        check("arst_valid_q", {31'h0, Valid_Q}, 32'h0);
        check("arst_result_comb", Result, 32'hABCD_E000);
        ImmExt = 32'h0BAD_F00D; #1;
        check("arst_result_track", Result, 32'h0BAD_F00D);

        // Reset held across an edge overrides capture
        @(posedge clk); #1;
        check("arst_edge_result_q", Result_Q, 32'h0000_0000);
        check("arst_edge_valid_q", {31'h0, Valid_Q}, 32'h0);

        // Release, then first valid edge captures normally
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_result_q", Result_Q, 32'h0BAD_F00D);
        check("post_rst_valid_q", {31'h0, Valid_Q}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_mux_stage.md
Name: result_mux_stage

Overview:
- Write-back result selector for the single-cycle RISC-V core.
- Picks the register-file write value from four sources: ALU result, formatted load data, PC+4, or the extended immediate.
- Formats load data for LB/LH/LW/LBU/LHU.
- Drives the result combinationally, and also through an optional registered copy with a valid flag for trace/pipeline use.

Parameters:
- RESET_VALUE, 32'h0000_0000, value loaded into Result_Q on reset.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- ALUResult  input  32  ALU output; bits [1:0] also give the load byte offset.
- ReadData  input  32  raw aligned word from data memory.
- PC_Plus_4  input  32  PC+4, used for JAL/JALR link.
- ImmExt  input  32  extended immediate, used for LUI.
- ResultSrc  input  2  source select.
- Funct3  input  3  load type, used only when ResultSrc=01.
- Valid_In  input  1  the current instruction writes back this cycle.
- Result  output  32  combinational selected result.
- Result_Q  output  32  registered result.
- Valid_Q  output  1  registered Valid_In.

Behaviour:
- Result is purely combinational. There is zero latency from any input to Result.
- ResultSrc decode:
  - 00 -> ALUResult
  - 01 -> LoadData
  - 10 -> PC_Plus_4
  - 11 -> ImmExt
- LoadData is derived from ReadData, Funct3 and off = ALUResult[1:0]:
  - 000 LB: byte ReadData[8*off+7 : 8*off], sign-extended to 32 bits.
  - 001 LH: half ReadData[16*off[1]+15 : 16*off[1]], sign-extended. off[0] is ignored; misalignment is not flagged.
  - 010 LW: ReadData unchanged; offset ignored.
  - 100 LBU: selected byte, zero-extended.
  - 101 LHU: selected half, zero-extended.
  - 011, 110, 111: ReadData unchanged.
- Funct3 and the offset have no effect unless ResultSrc=01.
- No X propagation from unselected sources: the output depends only on the selected source's bits.
- Registered path:
  - On rst_n low, asynchronously: Result_Q = RESET_VALUE, Valid_Q = 0.
  - Reset release is synchronised externally; the block does not require a specific release edge.
  - On each rising clk with rst_n high: Valid_Q <= Valid_In.
  - If Valid_In=1: Result_Q <= Result. If Valid_In=0: Result_Q holds its previous value.
- Reset asserted mid-operation overrides any capture in that cycle. Result (combinational) is unaffected by reset.
- Changing ResultSrc and data inputs on the same cycle: Result_Q captures the value consistent with the inputs present at the clock edge.

Test Plan:
- Basic select, combinational:
  - Setup: ALUResult=1, ReadData=2, PC_Plus_4=3, ImmExt=4, Funct3=010.
  - ResultSrc 00 -> Result=1; 01 -> 2; 10 -> 3; 11 -> 4. Each stage is 10 ns apart.
- Signed/unsigned byte loads:
  - Setup: ReadData=32'h80FF_7F01, ResultSrc=01.
  - Funct3=000: ALUResult[1:0]=00 -> 32'h0000_0001; 01 -> 32'h0000_007F; 10 -> 32'hFFFF_FFFF; 11 -> 32'hFFFF_FF80.
  - Funct3=100, off=10 -> 32'h0000_00FF.
- Halfword loads:
  - Setup: ReadData=32'h8001_7FFE.
  - LH off=00 -> 32'h0000_7FFE.
  - LH off=10 -> 32'hFFFF_8001.
  - LHU off=10 -> 32'h0000_8001.
  - LH off=01 -> same as off=00.
- Registered capture/hold:
  - Valid_In=1, Result=32'hDEAD_BEEF at an edge -> Result_Q=DEADBEEF and Valid_Q=1 after that edge.
  - Next edge with Valid_In=0 and a different Result -> Result_Q still DEADBEEF, Valid_Q=0.
- Async reset:
  - Drive rst_n low between clock edges -> Result_Q=0 and Valid_Q=0 immediately, without waiting for a clock edge.
  - Result continues to track the inputs during reset.
  - After release, the first valid edge captures normally.
- Non-load Funct3 independence:
  - ResultSrc=00, ALUResult=32'h1234_5673, sweep Funct3 through 000..111 -> Result stays 32'h1234_5673.
